// File: rtl/mem_loader_pkg.sv
// Shared types for mem_loader: memory-port command enums, loader FSM states and frame command bytes.
// RD/SEND states exist only when MEM_LOADER_READBACK_EN is defined.
package mem_loader_pkg;

   typedef enum logic [1:0] {
      MEM_NOP,
      MEM_READ,
      MEM_WRITE
   } memory_op_e;

   typedef enum logic [1:0] {
      ADDR_NOP,
      ADDR_LOAD,
      ADDR_INC
   } address_reg_op_e;

   typedef enum logic [3:0] {
      IDLE,
      GET_ALO,
      GET_AHI,
      GET_LEN,
      SET_ALO,
      SET_AHI,
      GET_DATA,
      WR,
`ifdef MEM_LOADER_READBACK_EN
      RD,
      SEND,
`endif
      INC
   } loader_state_e;

   localparam logic [7:0] LOADER_CMD_WRITE = 8'h01;
   localparam logic [7:0] LOADER_CMD_READ  = 8'h02;
   localparam logic [7:0] LOADER_CMD_RUN   = 8'h03;

   // States in which the loader takes a byte from the host.
   function automatic logic accepts_host(input loader_state_e s);
      return s inside {IDLE, GET_ALO, GET_AHI, GET_LEN, GET_DATA};
   endfunction

endpackage

// File: rtl/mem_loader.sv
// mem_loader: turns framed host bytes into memory-port commands while holding the CPU halted.
// Readback (READ command, RD/SEND states, resp_* stream) is compiled in with MEM_LOADER_READBACK_EN.
//
// state    | meaning
// IDLE     | wait for command byte; RUN releases the CPU
// GET_ALO  | take address low byte
// GET_AHI  | take address high byte
// GET_LEN  | take length (0 = 256)
// SET_ALO  | load low address byte into the memory address register
// SET_AHI  | load high address byte into the memory address register
// GET_DATA | take one payload byte
// WR       | write payload byte to memory
// RD       | read memory byte from the shared bus
// SEND     | offer read byte to the host until taken
// INC      | advance address, count down remaining bytes
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [7:0]      host_data,
   input  logic            host_valid,
   output logic            host_ready,
   output logic            cpu_halt,
   output memory_op_e      memory_op,
   output address_reg_op_e address_reg_op,
   output logic            data_word_selector,
   output logic            bus_selector,
   output logic [7:0]      bus_out,
   output logic            bus_oe,
   input  logic [7:0]      bus_in,
   output logic            busy,
   output logic            error
`ifdef MEM_LOADER_READBACK_EN
  ,output logic [7:0]      resp_data,
   output logic            resp_valid,
   input  logic            resp_ready
`endif
);

   loader_state_e     state, state_next;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        len_q;
   logic [7:0]        data_q;
   logic              accept, cmd_write, cmd_read, cmd_run;

   assign accept    = host_valid && host_ready;
   assign cmd_write = (host_data == LOADER_CMD_WRITE);
   assign cmd_run   = (host_data == LOADER_CMD_RUN);
   assign busy      = (state != IDLE);

`ifdef MEM_LOADER_READBACK_EN
   logic       is_write;
   logic [7:0] rdata_q;

   assign cmd_read  = (host_data == LOADER_CMD_READ);
   assign resp_data = rdata_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         is_write <= 1'b1;
         rdata_q  <= 8'h00;
      end else begin
         if (state == IDLE && accept) is_write <= cmd_write;
         if (state == RD) rdata_q <= bus_in;
      end
   end
`else
   // Bus readback is not built; keep the port without a dangling-input warning.
   logic unused_bus_in;
   assign cmd_read      = 1'b0;
   assign unused_bus_in = ^bus_in;
`endif

   always_comb begin
      state_next         = state;
      memory_op          = MEM_NOP;
      address_reg_op     = ADDR_NOP;
      data_word_selector = 1'b0;
      bus_selector       = 1'b0;
      bus_out            = 8'h00;
      bus_oe             = 1'b0;
`ifdef MEM_LOADER_READBACK_EN
      resp_valid         = 1'b0;
`endif
      case (state)
         IDLE:     if (accept && (cmd_write || cmd_read)) state_next = GET_ALO;
         GET_ALO:  if (accept) state_next = GET_AHI;
         GET_AHI:  if (accept) state_next = GET_LEN;
         GET_LEN:  if (accept) state_next = SET_ALO;
         SET_ALO: begin
            bus_out        = addr_q[7:0];
            bus_oe         = 1'b1;
            address_reg_op = ADDR_LOAD;
            state_next     = SET_AHI;
         end
         SET_AHI: begin
            bus_out            = addr_q[ADDR_W-1 -: 8];
            bus_oe             = 1'b1;
            address_reg_op     = ADDR_LOAD;
            data_word_selector = 1'b1;
`ifdef MEM_LOADER_READBACK_EN
            state_next         = is_write ? GET_DATA : RD;
`else
            state_next         = GET_DATA;
`endif
         end
         GET_DATA: if (accept) state_next = WR;
         WR: begin
            bus_out      = data_q;
            bus_oe       = 1'b1;
            bus_selector = 1'b1;
            memory_op    = MEM_WRITE;
            state_next   = INC;
         end
`ifdef MEM_LOADER_READBACK_EN
         RD: begin
            memory_op    = MEM_READ;
            bus_selector = 1'b1;
            state_next   = SEND;
         end
         SEND: begin
            resp_valid = 1'b1;
            if (resp_ready) state_next = INC;
         end
`endif
         INC: begin
            address_reg_op = ADDR_INC;
            // len_q == 1 means this INC brings the remaining count to zero.
            if (len_q == 8'd1) state_next = IDLE;
`ifdef MEM_LOADER_READBACK_EN
            else state_next = is_write ? GET_DATA : RD;
`else
            else state_next = GET_DATA;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         host_ready <= 1'b0;
         cpu_halt   <= 1'b1;
         error      <= 1'b0;
         addr_q     <= '0;
         len_q      <= 8'h00;
         data_q     <= 8'h00;
      end else begin
         state      <= state_next;
         host_ready <= accepts_host(state_next);
         if (state == IDLE && accept) begin
            if (cmd_write || cmd_read) begin
               cpu_halt <= 1'b1;
               error    <= 1'b0;
            end else if (cmd_run) begin
               cpu_halt <= 1'b0;
            end else begin
               error    <= 1'b1;
            end
         end
         if (accept) begin
            case (state)
               GET_ALO:  addr_q[7:0]          <= host_data;
               GET_AHI:  addr_q[ADDR_W-1 -: 8] <= host_data;
               GET_LEN:  len_q                <= host_data;
               GET_DATA: data_q               <= host_data;
               default:  ;
            endcase
         end
         if (state == INC) len_q <= len_q - 8'd1;
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: behavioural memory plus a frame-level reference model.
// Covers MEM_LOADER_READBACK_EN builds as well as the default build.
module tb_mem_loader;
   import mem_loader_pkg::*;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [7:0]      host_data = 8'h00;
   logic            host_valid = 1'b0;
   logic            host_ready;
   logic            cpu_halt;
   memory_op_e      memory_op;
   address_reg_op_e address_reg_op;
   logic            data_word_selector;
   logic            bus_selector;
   logic [7:0]      bus_out;
   logic            bus_oe;
   logic [7:0]      bus_in;
   logic            busy;
   logic            error;
`ifdef MEM_LOADER_READBACK_EN
   logic [7:0]      resp_data;
   logic            resp_valid;
   logic            resp_ready = 1'b0;
`endif

   always #5 clock = ~clock;

   mem_loader #(.ADDR_W(16)) dut (
      .clock(clock), .reset(reset),
      .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
      .cpu_halt(cpu_halt), .memory_op(memory_op), .address_reg_op(address_reg_op),
      .data_word_selector(data_word_selector), .bus_selector(bus_selector),
      .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
      .busy(busy), .error(error)
`ifdef MEM_LOADER_READBACK_EN
     ,.resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready)
`endif
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Memory environment: address register plus byte array on the shared bus.
   typedef struct {logic [15:0] a; logic [7:0] d;} wr_t;
   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [15:0] mar = 16'h0000;
   wr_t         wlog[$];

   always @(posedge clock) begin
      cyc++;
      if (memory_op == MEM_WRITE && bus_selector && bus_oe) begin
         mem[mar] = bus_out;
         wlog.push_back('{mar, bus_out});
      end
      if (address_reg_op == ADDR_LOAD && bus_oe) begin
         if (data_word_selector) mar[15:8] = bus_out;
         else                    mar[7:0]  = bus_out;
      end else if (address_reg_op == ADDR_INC) begin
         mar = mar + 16'd1;
      end
   end

   assign bus_in = (memory_op == MEM_READ && bus_selector) ? mem[mar] : 8'h00;

   // All tasks start and end on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      host_data  = b;
      host_valid = 1'b1;
      while (!host_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!host_ready) check("host_ready_timeout", {31'd0, host_ready}, 32'd1);
      @(negedge clock);
      host_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 2000) begin
         @(negedge clock);
         n++;
      end
      if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic random_gap();
      repeat ($urandom_range(0, 2)) @(negedge clock);
   endtask

   task automatic write_frame(input logic [15:0] addr, input logic [7:0] data[$], input bit gaps);
      int n = data.size();
      int t_len;
      int f0;
      logic [15:0] a;
      wlog.delete();
      send_byte(LOADER_CMD_WRITE);
      check("cmd_clears_error", {31'd0, error}, 32'd0);
      check("cmd_halts", {31'd0, cpu_halt}, 32'd1);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(n[7:0]);
      t_len = cyc;
      foreach (data[i]) begin
         if (gaps) random_gap();
         send_byte(data[i]);
      end
      wait_idle();
      // 2 address-setup cycles then 3 cycles per byte when the host never stalls
      if (!gaps) check("wr_latency", cyc - t_len, 2 + 3 * n);
      check("wr_count", wlog.size(), n);
      f0 = failures;
      foreach (data[i]) begin
         a = addr + i[15:0];
         ref_mem[a] = data[i];
         if (i < wlog.size() && failures == f0)
            check("wr_beat", {8'd0, wlog[i].a, wlog[i].d}, {8'd0, a, data[i]});
      end
   endtask

`ifdef MEM_LOADER_READBACK_EN
   task automatic recv_byte(output logic [7:0] d);
      int n = 0;
      d = 8'h00;
      forever begin
         resp_ready = ($urandom_range(0, 2) != 0);
         if (resp_valid && resp_ready) break;
         @(negedge clock);
         n++;
         if (n > 500) begin
            check("resp_timeout", {31'd0, resp_valid}, 32'd1);
            resp_ready = 1'b0;
            return;
         end
      end
      d = resp_data;
      @(negedge clock);
      resp_ready = 1'b0;
   endtask

   task automatic read_frame(input logic [15:0] addr, input int n);
      logic [7:0] d;
      logic [15:0] a;
      int n_left = n;
      send_byte(LOADER_CMD_READ);
      check("rd_cmd_clears_error", {31'd0, error}, 32'd0);
      send_byte(addr[7:0]);
      send_byte(addr[15:8]);
      send_byte(n_left[7:0]);
      for (int i = 0; i < n; i++) begin
         a = addr + i[15:0];
         recv_byte(d);
         check("rd_data", {24'd0, d}, {24'd0, ref_mem[a]});
      end
      wait_idle();
   endtask
`endif

   logic [7:0]  q[$];
   logic [15:0] frame_addr[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      repeat (3) @(negedge clock);
      check("rst_host_ready", {31'd0, host_ready}, 32'd0);
      check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd1);
      check("rst_memory_op", memory_op, MEM_NOP);
      check("rst_addr_op", address_reg_op, ADDR_NOP);
      check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_host_ready", {31'd0, host_ready}, 32'd1);

      q = {8'hAA, 8'hBB, 8'hCC};
      write_frame(16'h1234, q, 1'b0);

      send_byte(8'h7F);
      check("bad_cmd_error", {31'd0, error}, 32'd1);
      check("bad_cmd_idle", {31'd0, busy}, 32'd0);
      q = {8'($urandom)};
      write_frame(16'($urandom), q, 1'b0);

      send_byte(LOADER_CMD_RUN);
      check("run_releases", {31'd0, cpu_halt}, 32'd0);
      check("run_idle", {31'd0, busy}, 32'd0);
      q = {8'($urandom), 8'($urandom)};
      write_frame(16'($urandom), q, 1'b1);

`ifndef MEM_LOADER_READBACK_EN
      send_byte(LOADER_CMD_READ);
      check("read_unknown_error", {31'd0, error}, 32'd1);
      check("read_unknown_idle", {31'd0, busy}, 32'd0);
`endif

      for (int f = 0; f < 6; f++) begin
         logic [15:0] a;
         a = (f == 0) ? 16'hFFFE : 16'($urandom);
         q.delete();
         for (int i = 0; i < ((f == 0) ? 4 : int'($urandom_range(1, 6))); i++) q.push_back(8'($urandom));
         frame_addr.push_back(a);
         write_frame(a, q, f[0]);
      end

      q.delete();
      for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
      write_frame(16'h0000, q, 1'b0);

`ifdef MEM_LOADER_READBACK_EN
      begin
         logic [7:0] d;
         int n;
         q = {8'h55, 8'h66};
         write_frame(16'h0010, q, 1'b0);
         resp_ready = 1'b0;
         send_byte(LOADER_CMD_READ);
         send_byte(8'h10);
         send_byte(8'h00);
         send_byte(8'h02);
         n = 0;
         while (!resp_valid && n < 50) begin
            @(negedge clock);
            n++;
         end
         check("rb_first_valid", {31'd0, resp_valid}, 32'd1);
         check("rb_first_data", {24'd0, resp_data}, 32'h55);
         repeat (5) @(negedge clock);
         check("rb_stall_valid", {31'd0, resp_valid}, 32'd1);
         check("rb_stall_data", {24'd0, resp_data}, 32'h55);
         resp_ready = 1'b1;
         @(negedge clock);
         resp_ready = 1'b0;
         recv_byte(d);
         check("rb_second_data", {24'd0, d}, 32'h66);
         wait_idle();
      end
      foreach (frame_addr[i]) read_frame(frame_addr[i], int'($urandom_range(1, 5)));
`endif

      // reset in the middle of a write beat
      send_byte(LOADER_CMD_WRITE);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h02);
      @(negedge clock);
      @(negedge clock);
      send_byte(8'h77);
      check("pre_rst_memop", memory_op, MEM_WRITE);
      reset = 1'b1;
      #1;
      check("midwr_rst_memop", memory_op, MEM_NOP);
      check("midwr_rst_bus_oe", {31'd0, bus_oe}, 32'd0);
      check("midwr_rst_halt", {31'd0, cpu_halt}, 32'd1);
      check("midwr_rst_busy", {31'd0, busy}, 32'd0);
      check("midwr_rst_error", {31'd0, error}, 32'd0);
      check("midwr_rst_ready", {31'd0, host_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("midwr_no_commit", {24'd0, mem[16'h2000]}, {24'd0, ref_mem[16'h2000]});
      check("post_rst_ready", {31'd0, host_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
